nagu_seq: RTL and testbench

- Parametrised successor to the input/weight address generator: one sequenced AGU walking a tensor of up to NDIM nested loops with an innermost bit-plane (precision) loop.
- Job-based: configuration latched on start, addresses streamed over a valid/ready port, done pulse at end.
- Sits between the MVU controller and a data or weight bank read port. The team instantiates one per bank, replacing fixed 4-dimension, free-running address generation.

---
 rtl/nagu_pkg.sv | 37 +++
 rtl/nagu_dim.sv | 59 +++++
 rtl/nagu_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_nagu_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nagu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nagu_pkg
//  Purpose  : Shared definitions for the nagu_seq address generator: FSM state
//             encoding, the dimension limit and a helper that pulls one field
//             out of a packed per-dimension configuration vector.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package nagu_pkg;

  // Upper bound on nested loop dimensions supported by the packed helpers.
  localparam int MAXNDIM = 8;
  // Widest field the helper can return (address or length field).
  localparam int MAXW    = 32;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Any packed stride/length vector fits in this container after zero-extension.
  typedef logic [MAXNDIM*MAXW-1:0] pvec_t;

  // Return field idx (each w bits wide) of a packed vector, zero-extended.
  function automatic logic [MAXW-1:0] field_get(input pvec_t vec,
                                                input int unsigned idx,
                                                input int unsigned w);
    pvec_t            sh;
    logic [MAXW-1:0]  mask;
    sh   = vec >> (idx * w);
    mask = (w >= MAXW) ? '1 : ((MAXW'(1) << w) - MAXW'(1));
    return sh[MAXW-1:0] & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nagu_dim.sv
`default_nettype none
// ============================================================================
//  Module   : nagu_dim
//  Purpose  : One loop counter of the address generator. Compares its count
//             against the loop's last index and reports whether it can advance.
//             Priority between dimensions is resolved through lower_adv_i: a
//             dimension only acts (advance or wrap) when no lower one can.
//  Ports    : clk, clr        - clock, asynchronous active-high reset
//             init_i          - clear counter (job acceptance)
//             step_i          - an element finished and was accepted
//             lower_adv_i     - some lower dimension can advance
//             len_i           - last index of this loop
//             can_adv_o       - counter below its last index
//             adv_o           - this dimension is the one that advances
//  Revision : 1.0 - initial release
// ============================================================================
module nagu_dim #(
  parameter int BWLENGTH = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                init_i,
  input  logic                step_i,
  input  logic                lower_adv_i,
  input  logic [BWLENGTH-1:0] len_i,
  output logic                can_adv_o,
  output logic                adv_o
);

  logic [BWLENGTH-1:0] cnt_q;
  logic [BWLENGTH-1:0] cnt_d;
  logic                w_wrap;

  assign can_adv_o = (cnt_q < len_i);
  assign adv_o     = can_adv_o & ~lower_adv_i;
  // Saturated and nothing below can move: the selected dimension is above us.
  assign w_wrap    = ~can_adv_o & ~lower_adv_i;

  always_comb begin
    cnt_d = cnt_q;
    if (init_i) begin
      cnt_d = '0;
    end else if (step_i && adv_o) begin
      cnt_d = cnt_q + BWLENGTH'(1);
    end else if (step_i && w_wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nagu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : nagu_seq
//  Purpose  : Job-based sequenced address generator. Walks up to NDIM nested
//             loops with an innermost bit-plane loop and streams addresses
//             over a valid/ready port, pulsing done at job completion.
//  Ports    : clk, clr            - clock, asynchronous active-high reset
//             start, abort        - job request / synchronous cancel
//             cfg_base/prec       - base address, words per element (0 => 1)
//             cfg_stride          - packed per-dimension wrap jump
//             cfg_length          - packed per-dimension last index
//             addr_ready          - consumer accepts addr_out
//             addr_out/addr_valid - generated address stream
//             msb                 - current word is bit plane 0
//             on_j                - jump the current word's step will take
//             busy, done          - job in progress / completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module nagu_seq
  import nagu_pkg::*;
#(
  parameter int BWADDR   = 15,
  parameter int BWLENGTH = 8,
  parameter int NDIM     = 4,
  parameter int BPREC    = 6
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     abort,
  input  logic [BWADDR-1:0]        cfg_base,
  input  logic [BPREC-1:0]         cfg_prec,
  input  logic [NDIM*BWADDR-1:0]   cfg_stride,
  input  logic [NDIM*BWLENGTH-1:0] cfg_length,
  input  logic                     addr_ready,
  output logic [BWADDR-1:0]        addr_out,
  output logic                     addr_valid,
  output logic                     msb,
  output logic [NDIM:0]            on_j,
  output logic                     busy,
  output logic                     done
);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]               state_q, state_d;
  logic [BWADDR-1:0]        base_q;
  logic [BPREC-1:0]         prec_q;
  logic [NDIM*BWADDR-1:0]   stride_q;
  logic [NDIM*BWLENGTH-1:0] length_q;
  logic [BPREC-1:0]         bit_q, bit_d;
  logic [BWADDR-1:0]        ptr_q, ptr_d;
  logic [BWADDR-1:0]        addr_q, addr_d;

  // --------------------------------------------------------------------------
  // Control wires
  // --------------------------------------------------------------------------
  logic              w_accept;
  logic              w_run;
  logic              w_hs;
  logic              w_elem_last;
  logic              w_job_end;
  logic [BPREC-1:0]  w_prec_eff;
  logic [BWADDR-1:0] w_jump;
  logic [NDIM-1:0]   w_can_adv;
  logic [NDIM-1:0]   w_adv;
  // w_lower[k]: some dimension below k can advance; w_lower[NDIM]: any can.
  logic [NDIM:0]     w_lower;
  logic [BWADDR-1:0] w_stride [NDIM];
  logic              w_unused_stride;

  assign w_accept    = (state_q == ST_IDLE) && start;
  assign w_run       = (state_q == ST_RUN);
  // abort masks the handshake so it wins over a coincident final step.
  assign w_hs        = w_run && addr_ready && !abort;
  assign w_elem_last = (bit_q == (prec_q - BPREC'(1)));
  assign w_job_end   = w_hs && w_elem_last && !w_lower[NDIM];
  assign w_prec_eff  = (cfg_prec == '0) ? BPREC'(1) : cfg_prec;

  // --------------------------------------------------------------------------
  // Loop dimensions
  // --------------------------------------------------------------------------
  assign w_lower[0] = 1'b0;

  for (genvar k = 0; k < NDIM; k++) begin : g_dim
    logic [BWLENGTH-1:0] w_len;

    assign w_len       = BWLENGTH'(field_get(pvec_t'(length_q), k, BWLENGTH));
    assign w_stride[k] = BWADDR'(field_get(pvec_t'(stride_q), k, BWADDR));
    assign w_lower[k+1] = w_lower[k] | w_can_adv[k];

    nagu_dim #(
      .BWLENGTH (BWLENGTH)
    ) u_dim (
      .clk         (clk),
      .clr         (clr),
      .init_i      (w_accept),
      .step_i      (w_hs && w_elem_last),
      .lower_adv_i (w_lower[k]),
      .len_i       (w_len),
      .can_adv_o   (w_can_adv[k]),
      .adv_o       (w_adv[k])
    );
  end

  // The outermost stride would only apply when the whole job wraps, which
  // instead ends the job.
  assign w_unused_stride = ^w_stride[NDIM-1];

  // Pointer jump for the selected dimension: dim 0 advancing moves one element
  // (prec words); dim k advancing means dim k-1 wrapped, so stride[k-1] applies.
  always_comb begin
    w_jump = BWADDR'(prec_q);
    for (int k = 1; k < NDIM; k++) begin
      if (w_adv[k]) begin
        w_jump = w_stride[k-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath next state
  // --------------------------------------------------------------------------
  always_comb begin
    bit_d  = bit_q;
    ptr_d  = ptr_q;
    addr_d = addr_q;
    if (w_accept) begin
      bit_d  = '0;
      ptr_d  = '0;
      addr_d = cfg_base;
    end else if (w_hs) begin
      if (!w_elem_last) begin
        bit_d  = bit_q + BPREC'(1);
        addr_d = base_q + ptr_q + BWADDR'(bit_d);
      end else begin
        bit_d  = '0;
        ptr_d  = ptr_q + w_jump;
        addr_d = base_q + ptr_d;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      base_q   <= '0;
      prec_q   <= '0;
      stride_q <= '0;
      length_q <= '0;
      bit_q    <= '0;
      ptr_q    <= '0;
      addr_q   <= '0;
    end else begin
      if (w_accept) begin
        base_q   <= cfg_base;
        prec_q   <= w_prec_eff;
        stride_q <= cfg_stride;
        length_q <= cfg_length;
      end
      bit_q  <= bit_d;
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (w_job_end) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  assign addr_out = addr_q;

  always_comb begin
    addr_valid = w_run;
    busy       = w_run;
    done       = (state_q == ST_FIN);
    msb        = w_run && (bit_q == '0);
    on_j       = '0;
    // Dim k selected means dim k-1 (the highest wrapped) reports on bit k, so
    // the low bits are exactly the advance flags; nothing left means job end.
    if (w_run && w_elem_last) begin
      on_j = {~w_lower[NDIM], w_adv};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nagu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nagu_seq
//  Purpose  : Self-checking bench for nagu_seq (NDIM=2 instance).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nagu_seq;

  localparam int BWADDR   = 15;
  localparam int BWLENGTH = 8;
  localparam int NDIM     = 2;
  localparam int BPREC    = 6;

  logic                     clk = 1'b0;
  logic                     clr;
  logic                     start;
  logic                     abort;
  logic [BWADDR-1:0]        cfg_base;
  logic [BPREC-1:0]         cfg_prec;
  logic [NDIM*BWADDR-1:0]   cfg_stride;
  logic [NDIM*BWLENGTH-1:0] cfg_length;
  logic                     addr_ready;
  logic [BWADDR-1:0]        addr_out;
  logic                     addr_valid;
  logic                     msb;
  logic [NDIM:0]            on_j;
  logic                     busy;
  logic                     done;

  nagu_seq #(
    .BWADDR   (BWADDR),
    .BWLENGTH (BWLENGTH),
    .NDIM     (NDIM),
    .BPREC    (BPREC)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .abort      (abort),
    .cfg_base   (cfg_base),
    .cfg_prec   (cfg_prec),
    .cfg_stride (cfg_stride),
    .cfg_length (cfg_length),
    .addr_ready (addr_ready),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .msb        (msb),
    .on_j       (on_j),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BWADDR-1:0] addr;
    logic              msb;
    logic [NDIM:0]     onj;
  } vec_t;

  vec_t              tbl [12];
  int                n_cmp = 0;
  int                n_bad = 0;
  logic [BWADDR-1:0] q_got [$];
  logic [BWADDR-1:0] q_exp [$];
  int                n_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Launch a job at a falling edge; returns at the falling edge where the
  // first word is visible. cfg is then scrambled to show it was latched.
  task automatic start_job(input logic [BWADDR-1:0] b, input logic [BPREC-1:0] p,
                           input logic [7:0] l0, input logic [7:0] l1,
                           input logic [BWADDR-1:0] s0, input logic [BWADDR-1:0] s1);
    @(negedge clk);
    cfg_base   = b;
    cfg_prec   = p;
    cfg_length = {l1, l0};
    cfg_stride = {s1, s0};
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cfg_base   = ~b;
    cfg_prec   = p + 6'd3;
    cfg_length = '1;
    cfg_stride = '1;
  endtask

  // Consume words until done (bounded). Optionally random ready and a
  // mid-job start pulse at cycle inj.
  task automatic collect(input bit rnd, input int inj);
    logic              rdy;
    logic              prev_stall;
    logic [BWADDR-1:0] prev_addr;
    q_got.delete();
    n_done     = 0;
    prev_stall = 1'b0;
    prev_addr  = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (prev_stall) chk("stall_hold", 32'(addr_out), 32'(prev_addr));
      if (done) begin
        n_done++;
        break;
      end
      if (cyc == inj)     start = 1'b1;
      if (cyc == inj + 2) start = 1'b0;
      rdy        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      addr_ready = rdy;
      if (addr_valid && rdy) q_got.push_back(addr_out);
      prev_stall = addr_valid && !rdy;
      prev_addr  = addr_out;
      @(negedge clk);
    end
    start      = 1'b0;
    addr_ready = 1'b1;
    chk("job_done_seen", 32'(n_done), 32'd1);
  endtask

  task automatic cmp_stream(input string nm);
    chk({nm, "_len"}, 32'(q_got.size()), 32'(q_exp.size()));
    for (int i = 0; i < q_exp.size(); i++) begin
      if (i < q_got.size()) chk($sformatf("%s_w%0d", nm, i + 1), 32'(q_got[i]), 32'(q_exp[i]));
    end
  endtask

  task automatic set_basic_exp();
    q_exp.delete();
    for (int i = 0; i < 12; i++) q_exp.push_back(tbl[i].addr);
  endtask

  initial begin
    // Basic walk: base 100, prec 2, length0=2, length1=1. Stride field 0 is
    // the jump added when dim 0 wraps: ptr 4 -> 10, giving 110 after 105.
    tbl[0]  = '{15'd100, 1'b1, 3'b000};
    tbl[1]  = '{15'd101, 1'b0, 3'b001};
    tbl[2]  = '{15'd102, 1'b1, 3'b000};
    tbl[3]  = '{15'd103, 1'b0, 3'b001};
    tbl[4]  = '{15'd104, 1'b1, 3'b000};
    tbl[5]  = '{15'd105, 1'b0, 3'b010};
    tbl[6]  = '{15'd110, 1'b1, 3'b000};
    tbl[7]  = '{15'd111, 1'b0, 3'b001};
    tbl[8]  = '{15'd112, 1'b1, 3'b000};
    tbl[9]  = '{15'd113, 1'b0, 3'b001};
    tbl[10] = '{15'd114, 1'b1, 3'b000};
    tbl[11] = '{15'd115, 1'b0, 3'b100};

    clr        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_base   = '0;
    cfg_prec   = '0;
    cfg_stride = '0;
    cfg_length = '0;
    addr_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_addr",  32'(addr_out),   32'd0);
    chk("rst_valid", 32'(addr_valid), 32'd0);
    chk("rst_msb",   32'(msb),        32'd0);
    chk("rst_onj",   32'(on_j),       32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(done),       32'd0);
    @(negedge clk);
    clr = 1'b0;

    // abort alone in IDLE does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);

    // Basic walk, table-driven
    start_job(15'd100, 6'd2, 8'd2, 8'd1, 15'd6, 15'd50);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("walk_valid_w%0d", i + 1), 32'(addr_valid), 32'd1);
      chk($sformatf("walk_busy_w%0d",  i + 1), 32'(busy),       32'd1);
      chk($sformatf("walk_addr_w%0d",  i + 1), 32'(addr_out),   32'(tbl[i].addr));
      chk($sformatf("walk_msb_w%0d",   i + 1), 32'(msb),        32'(tbl[i].msb));
      chk($sformatf("walk_onj_w%0d",   i + 1), 32'(on_j),       32'(tbl[i].onj));
      chk($sformatf("walk_done_w%0d",  i + 1), 32'(done),       32'd0);
      @(negedge clk);
    end
    chk("walk_fin_done",  32'(done),       32'd1);
    chk("walk_fin_valid", 32'(addr_valid), 32'd0);
    chk("walk_fin_busy",  32'(busy),       32'd0);
    @(negedge clk);
    chk("walk_done_pulse", 32'(done), 32'd0);

    // Backpressure
    start_job(15'd100, 6'd2, 8'd2, 8'd1, 15'd6, 15'd50);
    collect(1'b1, -10);
    set_basic_exp();
    cmp_stream("bp");

    // Degenerate single word at top of address space
    start_job(15'd32767, 6'd0, 8'd0, 8'd0, 15'd0, 15'd0);
    chk("degen_msb", 32'(msb),  32'd1);
    chk("degen_onj", 32'(on_j), 32'b100);
    collect(1'b0, -10);
    q_exp.delete();
    q_exp.push_back(15'd32767);
    cmp_stream("degen");

    // Address wrap modulo 2^15
    start_job(15'd32767, 6'd1, 8'd1, 8'd0, 15'd0, 15'd0);
    chk("wrap_onj", 32'(on_j), 32'b001);
    collect(1'b0, -10);
    q_exp.delete();
    q_exp.push_back(15'd32767);
    q_exp.push_back(15'd0);
    cmp_stream("wrap");

    // start during a job is ignored
    start_job(15'd100, 6'd2, 8'd2, 8'd1, 15'd6, 15'd50);
    collect(1'b0, 4);
    set_basic_exp();
    cmp_stream("midstart");
    @(negedge clk);
    chk("midstart_idle_busy", 32'(busy), 32'd0);

    // abort on word 5
    start_job(15'd100, 6'd2, 8'd2, 8'd1, 15'd6, 15'd50);
    repeat (4) @(negedge clk);
    chk("abort5_addr", 32'(addr_out), 32'd104);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort5_valid", 32'(addr_valid), 32'd0);
    chk("abort5_busy",  32'(busy),       32'd0);
    chk("abort5_done",  32'(done),       32'd0);
    @(negedge clk);
    chk("abort5_done2", 32'(done), 32'd0);

    // abort coincident with the final handshake
    start_job(15'd100, 6'd2, 8'd2, 8'd1, 15'd6, 15'd50);
    repeat (11) @(negedge clk);
    chk("abortlast_addr", 32'(addr_out), 32'd115);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abortlast_done",  32'(done),       32'd0);
    chk("abortlast_valid", 32'(addr_valid), 32'd0);
    chk("abortlast_busy",  32'(busy),       32'd0);
    @(negedge clk);
    chk("abortlast_done2", 32'(done), 32'd0);

    // Asynchronous reset between edges mid-job, then a full job
    start_job(15'd100, 6'd2, 8'd2, 8'd1, 15'd6, 15'd50);
    repeat (3) @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk("aclr_addr",  32'(addr_out),   32'd0);
    chk("aclr_valid", 32'(addr_valid), 32'd0);
    chk("aclr_msb",   32'(msb),        32'd0);
    chk("aclr_onj",   32'(on_j),       32'd0);
    chk("aclr_busy",  32'(busy),       32'd0);
    chk("aclr_done",  32'(done),       32'd0);
    #1;
    clr = 1'b0;
    start_job(15'd100, 6'd2, 8'd2, 8'd1, 15'd6, 15'd50);
    collect(1'b0, -10);
    set_basic_exp();
    cmp_stream("postclr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
